// File: rtl/pipe_if_stage_if.sv
// Instruction-memory request/acknowledge bus between the fetch stage and memory.
interface pipe_if_stage_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        imem_ack;

  modport master (output imem_req, output imem_addr, input imem_rdata, input imem_ack);
  modport slave  (input imem_req, input imem_addr, output imem_rdata, output imem_ack);
endinterface

// File: rtl/pipe_if_stage.sv
// Instruction-fetch stage: issues fetches, buffers a word while ID stalls, and keeps
// a pending control-transfer target until the delay-slot fetch completes.
module pipe_if_stage (
  input  logic             clk,
  input  logic             clr,
  input  logic [1:0]       pcsrc,
  input  logic [31:0]      bpc,
  input  logic [31:0]      rpc,
  input  logic [31:0]      jpc,
  input  logic             nostall,
  pipe_if_stage_if.master  imem,
  output logic [31:0]      dpc4,
  output logic [31:0]      dinst,
  output logic             dvalid,
  output logic [31:0]      pc
);

  typedef enum logic [0:0] {StFetch, StHeld} state_t;

  state_t      state;
  logic        rvalid;
  logic [31:0] rtarget;
  logic [31:0] fetch_buf;
  logic [31:0] pc_plus4;
  logic [31:0] tgt;
  logic [31:0] npc;

  always_comb begin
    pc_plus4 = pc + 32'd4;
    tgt      = pc_plus4;
    unique case (pcsrc)
      2'b00: tgt = pc_plus4;
      2'b01: tgt = bpc;
      2'b10: tgt = rpc;
      2'b11: tgt = jpc;
    endcase
    // A recorded transfer wins over whatever ID presents now (ID holds a bubble then).
    npc = rvalid ? rtarget : tgt;
  end

  assign imem.imem_req  = (state == StFetch) && !clr;
  assign imem.imem_addr = pc;

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state     <= StFetch;
      pc        <= 32'd0;
      dpc4      <= 32'd0;
      dinst     <= 32'd0;
      dvalid    <= 1'b0;
      rvalid    <= 1'b0;
      rtarget   <= 32'd0;
      fetch_buf <= 32'd0;
    end else begin
      unique case (state)
        StFetch: begin
          if (imem.imem_ack) begin
            if (nostall) begin
              dinst  <= imem.imem_rdata;
              dpc4   <= pc_plus4;
              dvalid <= 1'b1;
              pc     <= npc;
              rvalid <= 1'b0;
            end else begin
              fetch_buf <= imem.imem_rdata;
              state     <= StHeld;
            end
          end else if (nostall) begin
            // Only a real instruction in ID may redirect; a bubble never does.
            if (dvalid && (pcsrc != 2'b00)) begin
              rvalid  <= 1'b1;
              rtarget <= tgt;
            end
            dinst  <= 32'd0;
            dvalid <= 1'b0;
          end
        end
        StHeld: begin
          if (nostall) begin
            dinst  <= fetch_buf;
            dpc4   <= pc_plus4;
            dvalid <= 1'b1;
            pc     <= npc;
            rvalid <= 1'b0;
            state  <= StFetch;
          end
        end
        default: state <= StFetch;
      endcase
    end
  end

endmodule

// File: tb/tb_pipe_if_stage.sv
// Bench for pipe_if_stage: directed vector table, hand sequences for wrap and reset,
// then random traffic against a queue-based reference model.
module tb_pipe_if_stage;

  logic        clk = 1'b0;
  logic        clr;
  logic [1:0]  pcsrc;
  logic [31:0] bpc, rpc, jpc;
  logic        nostall;
  logic [31:0] dpc4, dinst, pc;
  logic        dvalid;

  int n_checks = 0;
  int n_errors = 0;

  pipe_if_stage_if bus ();

  pipe_if_stage dut (
    .clk     (clk),
    .clr     (clr),
    .pcsrc   (pcsrc),
    .bpc     (bpc),
    .rpc     (rpc),
    .jpc     (jpc),
    .nostall (nostall),
    .imem    (bus),
    .dpc4    (dpc4),
    .dinst   (dinst),
    .dvalid  (dvalid),
    .pc      (pc)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] memf(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Memory answers whatever address the DUT currently presents.
  task automatic cyc(input logic [1:0] ps, input logic ns, input logic ak);
    pcsrc            = ps;
    nostall          = ns;
    bus.imem_ack     = ak;
    bus.imem_rdata   = memf(bus.imem_addr);
    tick();
  endtask

  typedef struct {
    logic [1:0]  pcsrc;
    logic        nostall;
    logic        ack;
    logic        req;
    logic [31:0] addr;
    logic [31:0] dpc4;
    logic [31:0] dinst;
    logic        dvalid;
  } vec_t;

  vec_t tbl[13];

  // Reference model: fetch address, ID register, pending redirect and held word as queues.
  logic [31:0] m_pc, m_dpc4, m_dinst;
  logic        m_dvalid;
  logic [31:0] m_redir[$];
  logic [31:0] m_held[$];

  task automatic m_reset();
    m_pc = 0; m_dpc4 = 0; m_dinst = 0; m_dvalid = 0;
    m_redir.delete();
    m_held.delete();
  endtask

  task automatic m_deliver(input logic [31:0] w, input logic [31:0] npc);
    m_dinst  = w;
    m_dpc4   = m_pc + 32'd4;
    m_dvalid = 1'b1;
    m_pc     = npc;
    m_redir.delete();
  endtask

  task automatic m_edge(input logic c, input logic [1:0] ps, input logic ns, input logic ak);
    logic [31:0] t, npc, w;
    if (c) begin
      m_reset();
      return;
    end
    t = (ps == 2'd0) ? m_pc + 32'd4 : (ps == 2'd1) ? bpc : (ps == 2'd2) ? rpc : jpc;
    npc = (m_redir.size() != 0) ? m_redir[0] : t;
    if (m_held.size() == 0) begin
      if (ak) begin
        if (ns) m_deliver(memf(m_pc), npc);
        else    m_held.push_back(memf(m_pc));
      end else if (ns) begin
        if (m_dvalid && ps != 2'd0) begin
          m_redir.delete();
          m_redir.push_back(t);
        end
        m_dinst  = 0;
        m_dvalid = 0;
      end
    end else if (ns) begin
      w = m_held.pop_front();
      m_deliver(w, npc);
    end
  endtask

  initial begin
    clr = 1'b1; pcsrc = 2'b00; nostall = 1'b1;
    bpc = 32'h100; rpc = 32'h200; jpc = 32'h300;
    bus.imem_ack = 1'b1; bus.imem_rdata = 32'hDEAD_BEEF;

    tbl[0]  = '{2'b00, 1'b1, 1'b1, 1'b1, 32'h4,   32'h4,   memf(32'h0),   1'b1};
    tbl[1]  = '{2'b00, 1'b1, 1'b1, 1'b1, 32'h8,   32'h8,   memf(32'h4),   1'b1};
    tbl[2]  = '{2'b00, 1'b1, 1'b1, 1'b1, 32'hC,   32'hC,   memf(32'h8),   1'b1};
    tbl[3]  = '{2'b00, 1'b1, 1'b1, 1'b1, 32'h10,  32'h10,  memf(32'hC),   1'b1};
    tbl[4]  = '{2'b00, 1'b0, 1'b1, 1'b0, 32'h10,  32'h10,  memf(32'hC),   1'b1};
    tbl[5]  = '{2'b00, 1'b0, 1'b1, 1'b0, 32'h10,  32'h10,  memf(32'hC),   1'b1};
    tbl[6]  = '{2'b00, 1'b1, 1'b0, 1'b1, 32'h14,  32'h14,  memf(32'h10),  1'b1};
    tbl[7]  = '{2'b01, 1'b1, 1'b0, 1'b1, 32'h14,  32'h14,  32'h0,         1'b0};
    tbl[8]  = '{2'b01, 1'b1, 1'b0, 1'b1, 32'h14,  32'h14,  32'h0,         1'b0};
    tbl[9]  = '{2'b00, 1'b1, 1'b1, 1'b1, 32'h100, 32'h18,  memf(32'h14),  1'b1};
    tbl[10] = '{2'b10, 1'b1, 1'b1, 1'b1, 32'h200, 32'h104, memf(32'h100), 1'b1};
    tbl[11] = '{2'b11, 1'b1, 1'b1, 1'b1, 32'h300, 32'h204, memf(32'h200), 1'b1};
    tbl[12] = '{2'b00, 1'b0, 1'b0, 1'b1, 32'h300, 32'h204, memf(32'h200), 1'b1};

    tick();
    tick();
    chk("rst_pc", pc, 32'h0);
    chk("rst_dpc4", dpc4, 32'h0);
    chk("rst_dinst", dinst, 32'h0);
    chk("rst_dvalid", {31'd0, dvalid}, 32'h0);
    chk("rst_req", {31'd0, bus.imem_req}, 32'h0);

    clr = 1'b0;
    #1;
    chk("first_req", {31'd0, bus.imem_req}, 32'h1);
    chk("first_addr", bus.imem_addr, 32'h0);

    for (int i = 0; i < 13; i++) begin
      cyc(tbl[i].pcsrc, tbl[i].nostall, tbl[i].ack);
      chk($sformatf("row%0d_req", i), {31'd0, bus.imem_req}, {31'd0, tbl[i].req});
      chk($sformatf("row%0d_addr", i), bus.imem_addr, tbl[i].addr);
      chk($sformatf("row%0d_pc", i), pc, tbl[i].addr);
      chk($sformatf("row%0d_dpc4", i), dpc4, tbl[i].dpc4);
      chk($sformatf("row%0d_dinst", i), dinst, tbl[i].dinst);
      chk($sformatf("row%0d_dvalid", i), {31'd0, dvalid}, {31'd0, tbl[i].dvalid});
    end

    // PC+4 wrap at the top of the address space.
    jpc = 32'hFFFF_FFFC;
    cyc(2'b11, 1'b1, 1'b1);
    chk("wrap_pc", pc, 32'hFFFF_FFFC);
    cyc(2'b00, 1'b1, 1'b1);
    chk("wrap_dpc4", dpc4, 32'h0);
    chk("wrap_dinst", dinst, memf(32'hFFFF_FFFC));
    chk("wrap_addr", bus.imem_addr, 32'h0);

    // Reset while a fetch at 0x40 is outstanding; the late ack must be dropped.
    jpc = 32'h40;
    cyc(2'b11, 1'b1, 1'b1);
    chk("c40_addr", bus.imem_addr, 32'h40);
    cyc(2'b00, 1'b1, 1'b0);
    chk("c40_bubble", {31'd0, dvalid}, 32'h0);
    clr = 1'b1;
    bus.imem_ack = 1'b1;
    #1;
    chk("clr_pc", pc, 32'h0);
    chk("clr_dvalid", {31'd0, dvalid}, 32'h0);
    chk("clr_req", {31'd0, bus.imem_req}, 32'h0);
    tick();
    chk("clr_hold_dinst", dinst, 32'h0);
    chk("clr_hold_dpc4", dpc4, 32'h0);
    clr = 1'b0;
    bus.imem_ack = 1'b0;
    #1;
    chk("rel_req", {31'd0, bus.imem_req}, 32'h1);
    chk("rel_addr", bus.imem_addr, 32'h0);
    cyc(2'b00, 1'b1, 1'b1);
    chk("rel_dpc4", dpc4, 32'h4);
    chk("rel_dinst", dinst, memf(32'h0));

    // Random traffic from a clean reset.
    clr = 1'b1;
    tick();
    m_reset();
    clr = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      logic c;
      c       = ($urandom_range(0, 59) == 0);
      clr     = c;
      bpc     = $urandom & 32'hFFFF_FFFC;
      rpc     = $urandom & 32'hFFFF_FFFC;
      jpc     = $urandom_range(0, 3) == 0 ? 32'hFFFF_FFFC : ($urandom & 32'hFFFF_FFFC);
      pcsrc   = 2'($urandom_range(0, 3));
      nostall = ($urandom_range(0, 3) != 0);
      bus.imem_ack = ($urandom_range(0, 1) == 1);
      #1;
      bus.imem_rdata = memf(bus.imem_addr);
      m_edge(c, pcsrc, nostall, bus.imem_ack);
      tick();
      clr = 1'b0;
      #1;
      chk("rnd_pc", pc, m_pc);
      chk("rnd_addr", bus.imem_addr, m_pc);
      chk("rnd_req", {31'd0, bus.imem_req}, {31'd0, m_held.size() == 0});
      chk("rnd_dpc4", dpc4, m_dpc4);
      chk("rnd_dinst", dinst, m_dinst);
      chk("rnd_dvalid", {31'd0, dvalid}, {31'd0, m_dvalid});
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/pipe_if_stage.md
PIPE_IF_STAGE -- requirements
Module: pipe_if_stage

Interface
REQ-001 SHALL have port clk, input, 1, single clock; all state updates on rising edge.
REQ-002 SHALL have port clr, input, 1, reset; asynchronous, active-high.
REQ-003 SHALL have port pcsrc, input, 2, next-PC select from ID: 00 pc+4, 01 bpc, 10 rpc, 11 jpc.
REQ-004 SHALL have ports bpc, rpc, jpc, input, 32 each: branch target, register-jump target, jump target from ID.
REQ-005 SHALL have port nostall, input, 1, ID ready to accept a new instruction this cycle.
REQ-006 SHALL have ports imem_req (output, 1), imem_addr (output, 32), imem_rdata (input, 32), imem_ack (input, 1): instruction-memory request handshake.
REQ-007 SHALL have ports dpc4 (output, 32), dinst (output, 32), dvalid (output, 1): registered IF/ID outputs.
REQ-008 SHALL expose pc (output, 32): current fetch PC.

Function
REQ-009 SHALL hold states FETCH (request outstanding) and HELD (fetched word buffered, ID stalled).
REQ-010 FETCH: imem_req=1, imem_addr=pc; HELD: imem_req=0; imem_addr=pc in both.
REQ-011 imem_addr SHALL stay stable while imem_req=1 until the cycle imem_ack=1; imem_rdata is sampled only in that cycle; same-cycle ack (zero wait) is legal.
REQ-012 imem_ack SHALL be ignored in HELD and while clr=1.
REQ-013 Target selection: tgt = pcsrc 00 pc+4 (32-bit, wraps mod 2^32), 01 bpc, 10 rpc, 11 jpc.
REQ-014 Redirect latch rvalid/rtarget SHALL record a taken control transfer whose delay-slot fetch is incomplete.
REQ-015 npc = rvalid ? rtarget : tgt.
REQ-016 FETCH, ack=1, nostall=1: dinst<=imem_rdata, dpc4<=pc+4, dvalid<=1, pc<=npc, rvalid<=0; stay FETCH; next request issues the following cycle.
REQ-017 FETCH, ack=1, nostall=0: buffer imem_rdata internally; IF/ID, pc, rvalid hold; go HELD.
REQ-018 FETCH, ack=0, nostall=1: dinst<=0 (NOP), dvalid<=0, dpc4 holds, pc holds; if dvalid=1 and pcsrc!=00, rvalid<=1, rtarget<=tgt.
REQ-019 FETCH, ack=0, nostall=0: all registers hold.
REQ-020 HELD, nostall=1: dinst<=buffer, dpc4<=pc+4, dvalid<=1, pc<=npc, rvalid<=0; go FETCH.
REQ-021 HELD, nostall=0: all registers hold.
REQ-022 Exactly one delay-slot instruction SHALL follow every taken transfer; no flush; bubbles (dvalid=0, dinst=0) SHALL never set rvalid.
REQ-023 pcsrc/targets SHALL be sampled only in cycles where ID advances (nostall=1).
REQ-024 Each fetched word SHALL reach ID exactly once, in fetch order.

Reset
REQ-025 While clr=1: pc=0, dpc4=0, dinst=0, dvalid=0, rvalid=0, rtarget=0, buffer=0, state FETCH, imem_req=0.
REQ-026 clr assertion mid-fetch or in HELD SHALL abandon the outstanding request or buffered word without delivering it to ID.
REQ-027 First request SHALL be imem_addr=0x00000000 in the first rising edge after clr deasserts.

Verification
REQ-028 Zero-wait memory, nostall=1, pcsrc=00 -> imem_addr 0,4,8,...; dpc4 4,8,12,... one cycle later; dvalid=1 every cycle.
REQ-029 ID holds branch pcsrc=01 bpc=0x100 while fetching 0x8, ack 3 cycles late -> two bubbles (dvalid=0, dinst=0), then word at 0x8 delivered, next imem_addr=0x100.
REQ-030 ack at 0x10 with nostall=0 for 2 cycles -> imem_req=0 during HELD, dinst unchanged; on nostall=1 buffered word delivered with dpc4=0x14, then imem_addr=0x14.
REQ-031 pc=0xFFFFFFFC, pcsrc=00, ack -> dpc4=0x00000000, next imem_addr=0x00000000.
REQ-032 clr pulsed while waiting for ack at 0x40 -> dvalid=0, pc=0, late ack ignored; after release imem_addr=0x0.
